// File: rtl/trng_sample_ctrl_if.sv
// Stream and control bundle between the sampling controller, the counter and the readout side.
interface trng_sample_ctrl_if #(
    parameter int unsigned WORD_W = 32
);
    logic              start;
    logic              stop;
    logic              cnt_rst;
    logic [7:0]        count;
    logic              count_en;
    logic [WORD_W-1:0] dout;
    logic              dout_valid;
    logic              dout_ready;
    logic              busy;
    logic              error;
    logic              err_clr;

    // Environment side: issues commands, supplies counter results, consumes words.
    modport master (
        output start, stop, count, count_en, dout_ready, err_clr,
        input  cnt_rst, dout, dout_valid, busy, error
    );

    // Controller side.
    modport slave (
        input  start, stop, count, count_en, dout_ready, err_clr,
        output cnt_rst, dout, dout_valid, busy, error
    );
endinterface

// File: rtl/trng_sample_ctrl.sv
// Sequences a coherent-sampling counter, health-checks its results and packs
// COUNT[0] of accepted samples into words delivered on a valid/ready stream.
module trng_sample_ctrl #(
    parameter int unsigned WORD_W     = 32,
    parameter int unsigned CRST_CYC   = 16,
    parameter int unsigned WARMUP     = 4,
    parameter int unsigned ZERO_LIMIT = 3,
    parameter int unsigned REP_LIMIT  = 8
) (
    input logic                clk,
    input logic                rst,
    trng_sample_ctrl_if.slave  bus
);

    localparam int unsigned     NW        = (WORD_W > 1) ? $clog2(WORD_W) : 1;
    localparam logic [NW-1:0]   LAST_BIT  = NW'(WORD_W - 1);
    localparam logic [NW-1:0]   NB_ONE    = NW'(1);
    localparam logic [7:0]      CRST_LAST = 8'(CRST_CYC - 1);
    localparam logic [8:0]      WARM_N    = 9'(WARMUP);
    localparam logic [8:0]      ZL        = 9'(ZERO_LIMIT);
    localparam logic [8:0]      RL        = 9'(REP_LIMIT);

    typedef enum logic [1:0] {StIdle, StCrst, StWarm, StRun} state_e;

    state_e            state_q, state_d;
    logic [7:0]        crst_cnt_q, crst_cnt_d;
    logic [7:0]        warm_cnt_q, warm_cnt_d;
    logic [7:0]        zcnt_q, zcnt_d;
    logic [7:0]        rcnt_q, rcnt_d;
    logic [7:0]        last_q, last_d;
    logic [NW-1:0]     nbits_q, nbits_d;
    logic [WORD_W-1:0] shreg_q, shreg_d;
    logic [WORD_W-1:0] dout_q, dout_d;
    logic              dout_valid_q, dout_valid_d;
    logic              error_q, error_d;
    logic              cnt_rst_q, cnt_rst_d;
    logic              busy_q, busy_d;

    logic [8:0]        zcnt_inc, rcnt_inc;
    logic              fault;
    logic              word_done;
    logic [WORD_W-1:0] word;

    // Health counters as they would be after the current strobe; a fault is the strobe
    // that takes either run length up to its limit.
    always_comb begin
        zcnt_inc = (bus.count == 8'h00) ? {1'b0, zcnt_q} + 9'd1 : 9'd0;
        rcnt_inc = (bus.count == last_q) ? {1'b0, rcnt_q} + 9'd1 : 9'd1;
        fault    = (state_q == StRun) && bus.count_en && ((zcnt_inc >= ZL) || (rcnt_inc >= RL));
    end

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; STOP wins over everything except entering from IDLE.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: begin
                if (bus.start && !error_q) state_d = StCrst;
            end
            StCrst: begin
                if (bus.stop) begin
                    state_d = StIdle;
                end else if (crst_cnt_q == CRST_LAST) begin
                    if (WARMUP == 0) state_d = StRun;
                    else             state_d = StWarm;
                end
            end
            StWarm: begin
                if (bus.stop) begin
                    state_d = StIdle;
                end else if (bus.count_en && ({1'b0, warm_cnt_q} + 9'd1 == WARM_N)) begin
                    state_d = StRun;
                end
            end
            StRun: begin
                if (bus.stop || fault) state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    // Registered FSM outputs, derived from the state being entered.
    always_comb begin
        cnt_rst_d = (state_d == StIdle) || (state_d == StCrst);
        busy_d    = (state_d != StIdle);
    end

    // Datapath next state: phase counters, health tracking, packing and output word.
    always_comb begin
        crst_cnt_d   = (state_q == StCrst) ? crst_cnt_q + 8'd1 : 8'd0;
        warm_cnt_d   = 8'd0;
        if (state_q == StWarm) begin
            warm_cnt_d = bus.count_en ? warm_cnt_q + 8'd1 : warm_cnt_q;
        end

        zcnt_d       = zcnt_q;
        rcnt_d       = rcnt_q;
        last_d       = last_q;
        nbits_d      = nbits_q;
        shreg_d      = shreg_q;
        word_done    = 1'b0;
        word         = shreg_q;

        // Outside RUN nothing is in flight, so every new run starts from a clean slate.
        if (state_q != StRun) begin
            zcnt_d  = 8'd0;
            rcnt_d  = 8'd0;
            last_d  = 8'd0;
            nbits_d = '0;
            shreg_d = '0;
        end else if (bus.count_en && !fault) begin
            zcnt_d      = zcnt_inc[7:0];
            rcnt_d      = rcnt_inc[7:0];
            last_d      = bus.count;
            word[nbits_q] = bus.count[0];
            if (nbits_q == LAST_BIT) begin
                word_done = 1'b1;
                nbits_d   = '0;
                shreg_d   = '0;
            end else begin
                nbits_d   = nbits_q + NB_ONE;
                shreg_d   = word;
            end
        end

        // Leaving RUN drops any partial word; a word completed this cycle still goes out.
        if ((state_q == StRun) && (bus.stop || fault)) begin
            nbits_d = '0;
            shreg_d = '0;
        end

        dout_d       = dout_q;
        dout_valid_d = dout_valid_q;
        if (word_done && (!dout_valid_q || bus.dout_ready)) begin
            dout_d       = word;
            dout_valid_d = 1'b1;
        end else if (dout_valid_q && bus.dout_ready) begin
            dout_valid_d = 1'b0;
        end

        error_d = error_q;
        if (fault) begin
            error_d = 1'b1;
        end else if ((state_q == StIdle) && bus.err_clr) begin
            error_d = 1'b0;
        end
    end

    // Datapath and output registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            crst_cnt_q   <= 8'd0;
            warm_cnt_q   <= 8'd0;
            zcnt_q       <= 8'd0;
            rcnt_q       <= 8'd0;
            last_q       <= 8'd0;
            nbits_q      <= '0;
            shreg_q      <= '0;
            dout_q       <= '0;
            dout_valid_q <= 1'b0;
            error_q      <= 1'b0;
            cnt_rst_q    <= 1'b1;
            busy_q       <= 1'b0;
        end else begin
            crst_cnt_q   <= crst_cnt_d;
            warm_cnt_q   <= warm_cnt_d;
            zcnt_q       <= zcnt_d;
            rcnt_q       <= rcnt_d;
            last_q       <= last_d;
            nbits_q      <= nbits_d;
            shreg_q      <= shreg_d;
            dout_q       <= dout_d;
            dout_valid_q <= dout_valid_d;
            error_q      <= error_d;
            cnt_rst_q    <= cnt_rst_d;
            busy_q       <= busy_d;
        end
    end

    assign bus.cnt_rst    = cnt_rst_q;
    assign bus.busy       = busy_q;
    assign bus.error      = error_q;
    assign bus.dout       = dout_q;
    assign bus.dout_valid = dout_valid_q;

endmodule

// File: tb/tb_trng_sample_ctrl.sv
// Directed bench for trng_sample_ctrl with a cycle-level behavioural model and literal spot checks.
module tb_trng_sample_ctrl;

    localparam int WORD_W     = 32;
    localparam int CRST_CYC   = 16;
    localparam int WARMUP     = 4;
    localparam int ZERO_LIMIT = 3;
    localparam int REP_LIMIT  = 8;

    logic clk = 1'b0;
    logic rst = 1'b1;

    trng_sample_ctrl_if #(.WORD_W(WORD_W)) bus ();

    trng_sample_ctrl #(
        .WORD_W     (WORD_W),
        .CRST_CYC   (CRST_CYC),
        .WARMUP     (WARMUP),
        .ZERO_LIMIT (ZERO_LIMIT),
        .REP_LIMIT  (REP_LIMIT)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    // phase: 0 idle, 1 counter reset, 2 warm-up, 3 run
    int                m_phase;
    int                m_t;
    logic              m_err;
    logic              m_valid;
    logic [WORD_W-1:0] m_dout;
    bit                m_bits[$];
    logic [7:0]        m_hist[$];

    task automatic model_reset();
        m_phase = 0;
        m_t     = 0;
        m_err   = 1'b0;
        m_valid = 1'b0;
        m_dout  = '0;
        m_bits.delete();
        m_hist.delete();
    endtask

    function automatic bit zero_run();
        int n = m_hist.size();
        if (n < ZERO_LIMIT) return 1'b0;
        for (int i = 0; i < ZERO_LIMIT; i++) if (m_hist[n-1-i] != 8'h00) return 1'b0;
        return 1'b1;
    endfunction

    function automatic bit rep_run();
        int n = m_hist.size();
        if (n < REP_LIMIT) return 1'b0;
        for (int i = 1; i < REP_LIMIT; i++) if (m_hist[n-1-i] != m_hist[n-1]) return 1'b0;
        return 1'b1;
    endfunction

    task automatic model_step();
        bit                got_word = 1'b0;
        bit                faulted  = 1'b0;
        logic [WORD_W-1:0] w        = '0;
        case (m_phase)
            0: begin
                if (bus.start && !m_err) begin
                    m_phase = 1;
                    m_t     = 0;
                    m_hist.delete();
                    m_bits.delete();
                end
                if (bus.err_clr) m_err = 1'b0;
            end
            1: begin
                if (bus.stop) m_phase = 0;
                else begin
                    m_t++;
                    if (m_t == CRST_CYC) begin
                        m_phase = (WARMUP == 0) ? 3 : 2;
                        m_t     = 0;
                    end
                end
            end
            2: begin
                if (bus.stop) m_phase = 0;
                else if (bus.count_en) begin
                    m_t++;
                    if (m_t == WARMUP) m_phase = 3;
                end
            end
            default: begin
                if (bus.count_en) begin
                    m_hist.push_back(bus.count);
                    if (m_hist.size() > 300) void'(m_hist.pop_front());
                    if (zero_run() || rep_run()) begin
                        faulted = 1'b1;
                        m_err   = 1'b1;
                        m_phase = 0;
                        m_bits.delete();
                    end else begin
                        m_bits.push_back(bus.count[0]);
                        if (m_bits.size() == WORD_W) begin
                            for (int k = 0; k < WORD_W; k++) w[k] = m_bits[k];
                            m_bits.delete();
                            got_word = 1'b1;
                        end
                    end
                end
                if (!faulted && bus.stop) begin
                    m_phase = 0;
                    m_bits.delete();
                end
            end
        endcase
        if (got_word && (!m_valid || bus.dout_ready)) begin
            m_dout  = w;
            m_valid = 1'b1;
        end else if (m_valid && bus.dout_ready) begin
            m_valid = 1'b0;
        end
    endtask

    initial begin
        model_reset();
        forever begin
            @(posedge clk or posedge rst);
            if (rst) model_reset();
            else     model_step();
        end
    end

    // Every-cycle comparison of all outputs against the model.
    always @(negedge clk) begin
        check("cnt_rst", bus.cnt_rst, (m_phase <= 1));
        check("busy", bus.busy, (m_phase != 0));
        check("error", bus.error, m_err);
        check("dout_valid", bus.dout_valid, m_valid);
        check("dout", bus.dout, m_dout);
    end

    // ---------------- stimulus ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_start();
        bus.start = 1'b1; tick(); bus.start = 1'b0;
    endtask

    task automatic pulse_stop();
        bus.stop = 1'b1; tick(); bus.stop = 1'b0;
    endtask

    task automatic pulse_err_clr();
        bus.err_clr = 1'b1; tick(); bus.err_clr = 1'b0;
    endtask

    task automatic strobe(input logic [7:0] c);
        bus.count = c; bus.count_en = 1'b1; tick(); bus.count_en = 1'b0;
    endtask

    // Distinct, non-zero sample values whose LSB carries the wanted bit.
    function automatic logic [7:0] cval(input int i, input logic b);
        return 8'h80 | 8'((i % 32) << 1) | {7'd0, b};
    endfunction

    task automatic send_bits(input logic [31:0] w, input int n);
        for (int i = 0; i < n; i++) strobe(cval(i, w[i]));
    endtask

    task automatic begin_run();
        pulse_start();
        repeat (CRST_CYC) tick();
        repeat (WARMUP) strobe(8'h00);
    endtask

    task automatic probe();
        @(negedge clk);
    endtask

    initial begin
        int hi;
        logic [31:0] pat;
        bus.start = 1'b0; bus.stop = 1'b0; bus.count = 8'h00; bus.count_en = 1'b0;
        bus.dout_ready = 1'b1; bus.err_clr = 1'b0;
        rst = 1'b1;
        repeat (3) tick();
        probe();
        check("rst_cnt_rst", bus.cnt_rst, 1'b1);
        check("rst_busy", bus.busy, 1'b0);
        check("rst_valid", bus.dout_valid, 1'b0);
        check("rst_dout", bus.dout, 32'h0);
        tick();
        rst = 1'b0;
        tick();

        // T1: CNT_RST stays high for exactly CRST_CYC cycles after START.
        pulse_start();
        hi = 0;
        for (int i = 0; i < 40; i++) begin
            probe();
            if (bus.cnt_rst) hi++;
            else break;
        end
        check("crst_cycles", hi, 16);
        check("t1_busy", bus.busy, 1'b1);

        // T2: warm-up zeros are not health-checked; then pack 0xA5A53C3C LSB first.
        repeat (4) strobe(8'h00);
        pat = 32'hA5A53C3C;
        send_bits(pat, 31);
        probe();
        check("no_early_word", bus.dout_valid, 1'b0);
        strobe(cval(31, pat[31]));
        probe();
        check("t2_valid", bus.dout_valid, 1'b1);
        check("t2_dout", bus.dout, 32'hA5A53C3C);
        check("t2_error", bus.error, 1'b0);
        tick();
        probe();
        check("t2_valid_drop", bus.dout_valid, 1'b0);

        // T3: backpressure holds the first word and drops the second.
        bus.dout_ready = 1'b0;
        send_bits(32'h12345678, 32);
        probe();
        check("t3_w1_valid", bus.dout_valid, 1'b1);
        check("t3_w1", bus.dout, 32'h12345678);
        send_bits(32'hFFFF0000, 32);
        probe();
        check("t3_w2_dropped", bus.dout, 32'h12345678);
        bus.dout_ready = 1'b1;
        tick();
        probe();
        check("t3_valid_fall", bus.dout_valid, 1'b0);
        send_bits(32'h0F0F0F0F, 32);
        probe();
        check("t3_w3_valid", bus.dout_valid, 1'b1);
        check("t3_w3", bus.dout, 32'h0F0F0F0F);

        // T4: three zeros in RUN fault; START ignored until ERR_CLR.
        strobe(8'h00); strobe(8'h00);
        probe();
        check("t4_two_zeros_ok", bus.error, 1'b0);
        strobe(8'h00);
        probe();
        check("t4_error", bus.error, 1'b1);
        check("t4_idle", bus.busy, 1'b0);
        check("t4_cnt_rst", bus.cnt_rst, 1'b1);
        pulse_start();
        probe();
        check("t4_start_ignored", bus.busy, 1'b0);
        pulse_err_clr();
        probe();
        check("t4_err_clr", bus.error, 1'b0);
        begin_run();
        probe();
        check("t4_restart_busy", bus.busy, 1'b1);
        check("t4_restart_cnt_rst", bus.cnt_rst, 1'b0);

        // T5: seven repeats are fine, eight fault.
        repeat (7) strobe(8'h81);
        strobe(8'h82);
        probe();
        check("t5_seven_ok", bus.error, 1'b0);
        repeat (7) strobe(8'h81);
        probe();
        check("t5_seven_again_ok", bus.error, 1'b0);
        strobe(8'h81);
        probe();
        check("t5_eight_error", bus.error, 1'b1);
        check("t5_idle", bus.busy, 1'b0);
        check("t5_dout_kept", bus.dout, 32'h0F0F0F0F);

        // T6: STOP discards partial word; STOP on a completing strobe still delivers.
        pulse_err_clr();
        begin_run();
        for (int i = 0; i < 10; i++) strobe(8'(8'h41 + 2 * i));
        pulse_stop();
        probe();
        check("t6_stop_idle", bus.busy, 1'b0);
        begin_run();
        send_bits(32'h00000000, 32);
        probe();
        check("t6_no_old_bits_valid", bus.dout_valid, 1'b1);
        check("t6_no_old_bits", bus.dout, 32'h00000000);
        pat = 32'hDEADBEEF;
        send_bits(pat, 31);
        bus.stop = 1'b1;
        strobe(cval(31, pat[31]));
        bus.stop = 1'b0;
        probe();
        check("t6_stop_word_valid", bus.dout_valid, 1'b1);
        check("t6_stop_word", bus.dout, 32'hDEADBEEF);
        check("t6_stop_word_idle", bus.busy, 1'b0);

        // Asynchronous reset mid-RUN.
        begin_run();
        repeat (5) strobe(8'h93);
        #3;
        rst = 1'b1;
        #1;
        check("t6_arst_cnt_rst", bus.cnt_rst, 1'b1);
        check("t6_arst_busy", bus.busy, 1'b0);
        check("t6_arst_valid", bus.dout_valid, 1'b0);
        check("t6_arst_dout", bus.dout, 32'h0);
        check("t6_arst_error", bus.error, 1'b0);
        tick();
        tick();
        rst = 1'b0;
        repeat (3) tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete, total=%0d bad=%0d", total, bad);
        $fatal(1);
    end

endmodule
